// File: rtl/pong_pkg.sv
// Shared screen geometry, object bounds and colour codes for the pong graphics stage.
package pong_pkg;

    localparam logic [9:0] MAX_X      = 10'd640;
    localparam logic [9:0] MAX_Y      = 10'd480;

    localparam logic [9:0] WALL_X_L   = 10'd32;
    localparam logic [9:0] WALL_X_R   = 10'd35;

    localparam logic [9:0] PAD_X_L    = 10'd600;
    localparam logic [9:0] PAD_X_R    = 10'd603;
    localparam logic [9:0] PAD_Y_RST  = 10'd204;

    localparam logic [9:0] BALL_SIZE  = 10'd8;
    localparam logic [9:0] BALL_X_RST = 10'd316;
    localparam logic [9:0] BALL_Y_RST = 10'd236;

    localparam logic [2:0] RGB_BALL   = 3'b100;
    localparam logic [2:0] RGB_PAD    = 3'b010;
    localparam logic [2:0] RGB_WALL   = 3'b001;
    localparam logic [2:0] RGB_BG     = 3'b000;

endpackage

// File: rtl/ball_rom.sv
// 8x8 round-ball bitmap; MSB of each row is the leftmost pixel.
module ball_rom
    import pong_pkg::*;
(
    input  logic [2:0] addr,
    output logic [7:0] data
);

    always_comb begin
        case (addr)
            3'd0:    data = 8'h3C;
            3'd1:    data = 8'h7E;
            3'd2:    data = 8'hFF;
            3'd3:    data = 8'hFF;
            3'd4:    data = 8'hFF;
            3'd5:    data = 8'hFF;
            3'd6:    data = 8'h7E;
            default: data = 8'h3C;
        endcase
    end

endmodule

// File: rtl/pong_graph_anim.sv
// Pong pixel generator: wall, button-driven paddle and bouncing ball, updated once per frame
// during vertical blanking, with a registered RGB output aligned to the buffered sync signals.
module pong_graph_anim
    import pong_pkg::*;
#(
    parameter int PAD_H  = 72,
    parameter int PAD_V  = 4,
    parameter int BALL_V = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [1:0] btn,
    output logic [2:0] graph_rgb,
    output logic       hit,
    output logic       miss
);

    localparam logic [10:0] MISS_X   = 11'({1'b0, MAX_X} - {1'b0, BALL_SIZE});
    localparam logic [10:0] BOT_Y    = 11'({1'b0, MAX_Y} - 11'd2);
    localparam logic [9:0]  TOP_Y    = 10'd1;
    localparam logic [9:0]  WALL_HIT = 10'(WALL_X_R + 10'd1);
    localparam logic [10:0] PAD_LIM  = 11'(MAX_Y - 10'd1 - 10'(PAD_V));
    localparam logic signed [10:0] V_POS = 11'(BALL_V);
    localparam logic signed [10:0] V_NEG = -11'(BALL_V);

    logic [9:0] pad_y, pad_y_n;
    logic [9:0] ball_x, ball_x_n, ball_y, ball_y_n;
    logic signed [10:0] dx, dx_n, dy, dy_n;
    logic hit_n, miss_n;
    logic [10:0] sum_x, sum_y;

    wire refr_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd481);

    wire [10:0] pad_top = {1'b0, pad_y};
    wire [10:0] pad_bot = pad_top + 11'(PAD_H - 1);
    wire [10:0] ball_r  = {1'b0, ball_x} + 11'(BALL_SIZE - 10'd1);
    wire [10:0] ball_b  = {1'b0, ball_y} + 11'(BALL_SIZE - 10'd1);

    // Pixel classification against the current object positions.
    wire wall_on = (pixel_x >= WALL_X_L) && (pixel_x <= WALL_X_R);
    wire pad_on  = (pixel_x >= PAD_X_L) && (pixel_x <= PAD_X_R) &&
                   ({1'b0, pixel_y} >= pad_top) && ({1'b0, pixel_y} <= pad_bot);
    wire box_on  = (pixel_x >= ball_x) && ({1'b0, pixel_x} <= ball_r) &&
                   (pixel_y >= ball_y) && ({1'b0, pixel_y} <= ball_b);

    wire [9:0] row_off = pixel_y - ball_y;
    wire [9:0] col_off = pixel_x - ball_x;
    logic [7:0] rom_data;

    ball_rom u_ball_rom (
        .addr (row_off[2:0]),
        .data (rom_data)
    );

    wire [2:0] rom_col = 3'd7 - col_off[2:0];
    wire ball_on = box_on && rom_data[rom_col];

    logic [2:0] rgb_next;

    // NOTE: every signal gets a default before any branch, so no path leaves a latch behind.
    always_comb begin
        rgb_next = RGB_BG;
        if (video_on) begin
            if (ball_on)      rgb_next = RGB_BALL;
            else if (pad_on)  rgb_next = RGB_PAD;
            else if (wall_on) rgb_next = RGB_WALL;
        end
    end

    always_comb begin
        pad_y_n  = pad_y;
        ball_x_n = ball_x;
        ball_y_n = ball_y;
        dx_n     = dx;
        dy_n     = dy;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        sum_x    = '0;
        sum_y    = '0;
        if (refr_tick) begin
            if (btn == 2'b10 && pad_y > 10'(PAD_V))
                pad_y_n = pad_y - 10'(PAD_V);
            else if (btn == 2'b01 && pad_bot < PAD_LIM)
                pad_y_n = pad_y + 10'(PAD_V);

            if (ball_r >= MISS_X) begin
                miss_n   = 1'b1;
                ball_x_n = BALL_X_RST;
                ball_y_n = BALL_Y_RST;
                dx_n     = V_NEG;
                dy_n     = V_POS;
            end else begin
                if (ball_y <= TOP_Y)     dy_n = V_POS;
                else if (ball_b >= BOT_Y) dy_n = V_NEG;

                if (ball_x <= WALL_HIT) begin
                    dx_n = V_POS;
                end else if (ball_r >= {1'b0, PAD_X_L} && ball_r <= {1'b0, PAD_X_R} &&
                             ball_b >= pad_top && {1'b0, ball_y} <= pad_bot && dx > 11'sd0) begin
                    dx_n  = V_NEG;
                    hit_n = 1'b1;
                end

                // Two's-complement add; the bounds keep the result inside the 10-bit range.
                sum_x    = {1'b0, ball_x} + dx_n;
                sum_y    = {1'b0, ball_y} + dy_n;
                ball_x_n = sum_x[9:0];
                ball_y_n = sum_y[9:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_y     <= PAD_Y_RST;
            ball_x    <= BALL_X_RST;
            ball_y    <= BALL_Y_RST;
            dx        <= V_POS;
            dy        <= V_POS;
            hit       <= 1'b0;
            miss      <= 1'b0;
            graph_rgb <= RGB_BG;
        end else begin
            pad_y     <= pad_y_n;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            dx        <= dx_n;
            dy        <= dy_n;
            hit       <= hit_n;
            miss      <= miss_n;
            graph_rgb <= rgb_next;
        end
    end

endmodule

// File: tb/tb_pong_graph_anim.sv
// Directed bench for pong_graph_anim: frame ticks are driven directly, pixels probed one at a time.
module tb_pong_graph_anim;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_tick;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [1:0] btn;
    logic [2:0] graph_rgb;
    logic       hit;
    logic       miss;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    pong_graph_anim #(.PAD_H(72), .PAD_V(4), .BALL_V(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .btn       (btn),
        .graph_rgb (graph_rgb),
        .hit       (hit),
        .miss      (miss)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One refr_tick per call; the posedge that follows it has completed on return.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd481; video_on = 1'b0;
            @(negedge clk);
            p_tick = 1'b0; pixel_y = 10'd0;
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic vo,
                       input logic [2:0] exp);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo;
        @(negedge clk);
        check(tag, graph_rgb, exp);
    endtask

    initial begin
        rst = 1'b1; p_tick = 1'b0; video_on = 1'b0;
        pixel_x = '0; pixel_y = '0; btn = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_rgb", graph_rgb, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_pad_y", dut.pad_y, 204);
        check("rst_ball_x", dut.ball_x, 316);
        check("rst_ball_y", dut.ball_y, 236);
        check("rst_dx", dut.dx, 2);
        check("rst_dy", dut.dy, 2);
        rst = 1'b0;

        // One idle frame, then shape/priority probes around the ball at (318,238).
        frames(1);
        check("f1_ball_x", dut.ball_x, 318);
        check("f1_ball_y", dut.ball_y, 238);
        check("f1_pad_y", dut.pad_y, 204);
        pix("wall_34_100", 34, 100, 1'b1, 3'b001);
        pix("wall_32_479", 32, 479, 1'b1, 3'b001);
        pix("wall_edge_36", 36, 0, 1'b1, 3'b000);
        pix("ball_corner_off", 318, 238, 1'b1, 3'b000);
        pix("ball_r0_c3", 321, 238, 1'b1, 3'b100);
        pix("ball_r3_c0", 318, 241, 1'b1, 3'b100);
        pix("ball_r7_c7", 325, 245, 1'b1, 3'b000);
        pix("ball_outside", 326, 241, 1'b1, 3'b000);
        pix("pad_top", 600, 204, 1'b1, 3'b010);
        pix("pad_bot", 603, 275, 1'b1, 3'b010);
        pix("pad_below", 603, 276, 1'b1, 3'b000);
        pix("pad_right", 604, 210, 1'b1, 3'b000);
        pix("blank_ball", 321, 238, 1'b0, 3'b000);

        btn = 2'b11;
        frames(10);
        check("btn11_hold", dut.pad_y, 204);

        // Paddle down to its limit; ball bounces off the bottom and meets it at x=594,y=430.
        do_reset();
        btn = 2'b01;
        frames(50);
        check("pad_down_404", dut.pad_y, 404);
        frames(89);
        check("pre_hit_x", dut.ball_x, 594);
        check("pre_hit_y", dut.ball_y, 430);
        check("pad_down_hold", dut.pad_y, 404);
        pix("ball_over_pad", 600, 433, 1'b1, 3'b100);
        pix("pad_beside_ball", 601, 430, 1'b1, 3'b010);
        frames(1);
        check("hit_pulse", hit, 1);
        check("hit_dx", dut.dx, -2);
        @(negedge clk);
        check("hit_clear", hit, 0);
        check("post_hit_x", dut.ball_x, 592);
        check("post_hit_y", dut.ball_y, 428);

        // Paddle up to 4 and hold; ball escapes right at x=626.
        do_reset();
        btn = 2'b10;
        frames(50);
        check("pad_up_4", dut.pad_y, 4);
        frames(10);
        check("pad_up_hold", dut.pad_y, 4);
        frames(95);
        check("pre_miss_x", dut.ball_x, 626);
        check("pre_miss_y", dut.ball_y, 398);
        check("no_miss_yet", miss, 0);
        frames(1);
        check("miss_pulse", miss, 1);
        check("miss_no_hit", hit, 0);
        check("miss_ball_x", dut.ball_x, 316);
        check("miss_ball_y", dut.ball_y, 236);
        check("miss_dx", dut.dx, -2);
        check("miss_dy", dut.dy, 2);
        @(negedge clk);
        check("miss_clear", miss, 0);
        frames(1);
        check("relaunch_x", dut.ball_x, 314);
        check("relaunch_y", dut.ball_y, 238);

        // Asynchronous reset in the middle of a clock period.
        pix("pad_at_4", 600, 10, 1'b1, 3'b010);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check("async_rgb", graph_rgb, 0);
        check("async_pad_y", dut.pad_y, 204);
        check("async_ball_x", dut.ball_x, 316);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
